// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the data-bus blocks around the single-port data RAM.
//   DATA_W / ADDR_W  : data RAM word and address widths
//   IDLE/ISSUE/RWAIT : mem_arbiter FSM state encodings
//   MASTER_CPU/STACK : master ids used by the arbiter (0 = control, 1 = stack)
//   id_onehot()      : converts a master id into a per-master strobe pair
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int DATA_W = 14;
    localparam int ADDR_W = 12;

    // FSM states are plain 2-bit constants so older tools and netlists
    // that expect fixed encodings keep working.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RWAIT = 2'd2;

    localparam logic MASTER_CPU   = 1'b0;
    localparam logic MASTER_STACK = 1'b1;

    // Bit 0 belongs to master 0, bit 1 to master 1.
    function automatic logic [1:0] id_onehot(input logic id);
        logic [1:0] onehot;
        if (id == MASTER_STACK) begin
            onehot = 2'b10;
        end else begin
            onehot = 2'b01;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
//   req         in  2  request vector, bit i = master i
//   last_winner in  1  id of the master granted most recently
//   winner      out 1  id of the master to serve next (meaningful if any_req)
//   any_req     out 1  at least one request is pending
// A lone requester always wins; on a tie the master that did not win last
// time is chosen.
// ---------------------------------------------------------------------------
module rr_pick2
    import cpu_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic       winner,
    output logic       any_req
);

    // Winner selection from the request vector and the fairness pointer.
    always_comb begin
        any_req = |req;
        winner  = ~last_winner;
        case (req)
            2'b01:   winner = MASTER_CPU;
            2'b10:   winner = MASTER_STACK;
            2'b11:   winner = ~last_winner;
            default: winner = ~last_winner;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single-port data RAM between the control unit load/store path
// (master 0) and the stack unit spill/fill path (master 1). One access is in
// flight at a time; ties are broken round-robin.
//
// Parameters
//   DATA_W  data width
//   ADDR_W  address width
//   RD_LAT  RAM read latency in cycles, legal range 1..4
//
// Ports
//   clk                  in   clock, rising edge
//   reset                in   asynchronous active-low reset
//   m0_req/m1_req        in   request, held until that master's gnt
//   m0_we/m1_we          in   1 = write, 0 = read
//   m0_addr/m1_addr      in   access address
//   m0_wdata/m1_wdata    in   write data
//   m0_gnt/m1_gnt        out  one-cycle pulse: access issued to the RAM
//   m0_rvalid/m1_rvalid  out  one-cycle pulse: rdata holds this master's read
//   rdata                out  read data shared by both masters
//   ram_addr/ram_wdata   out  RAM address / write data
//   ram_rd/ram_wr        out  one-cycle RAM read / write strobes
//   ram_rdata            in   RAM read data, valid RD_LAT cycles after ram_rd
//
// Every output comes straight from a flop; the next-state block computes all
// values one cycle ahead, so gnt and the RAM strobe rise together in ISSUE.
// ---------------------------------------------------------------------------
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m1_req,
    input  logic              m0_we,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m0_gnt,
    output logic              m1_gnt,
    output logic              m0_rvalid,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_rd,
    output logic              ram_wr,
    input  logic [DATA_W-1:0] ram_rdata
);

    // Count value of the last RWAIT cycle; the counter starts at 0.
    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    // Registered state
    logic [1:0]        state;
    logic              last_winner;
    logic              lat_we;
    logic              lat_id;
    logic [1:0]        cnt;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;

    // Next-state values
    logic [1:0]        state_nxt;
    logic              last_winner_nxt;
    logic              lat_we_nxt;
    logic              lat_id_nxt;
    logic [1:0]        cnt_nxt;
    logic [1:0]        gnt_nxt;
    logic [1:0]        rvalid_nxt;
    logic              ram_rd_nxt;
    logic              ram_wr_nxt;
    logic [ADDR_W-1:0] ram_addr_nxt;
    logic [DATA_W-1:0] ram_wdata_nxt;
    logic [DATA_W-1:0] rdata_nxt;

    // Picker outputs
    logic              pick;
    logic              any_req;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;

    rr_pick2 u_pick (
        .req         ({m1_req, m0_req}),
        .last_winner (last_winner),
        .winner      (pick),
        .any_req     (any_req)
    );

    // Route the winning master's access fields.
    always_comb begin
        if (pick == MASTER_STACK) begin
            pick_we    = m1_we;
            pick_addr  = m1_addr;
            pick_wdata = m1_wdata;
        end else begin
            pick_we    = m0_we;
            pick_addr  = m0_addr;
            pick_wdata = m0_wdata;
        end
    end

    // FSM next state plus next values of every registered output.
    always_comb begin
        state_nxt       = state;
        last_winner_nxt = last_winner;
        lat_we_nxt      = lat_we;
        lat_id_nxt      = lat_id;
        cnt_nxt         = cnt;
        gnt_nxt         = 2'b00;
        rvalid_nxt      = 2'b00;
        ram_rd_nxt      = 1'b0;
        ram_wr_nxt      = 1'b0;
        ram_addr_nxt    = ram_addr;
        ram_wdata_nxt   = ram_wdata;
        rdata_nxt       = rdata;
        case (state)
            IDLE: begin
                if (any_req) begin
                    // Latch the winner straight into the RAM-facing flops so
                    // address, data, strobe and gnt all appear in ISSUE.
                    state_nxt       = ISSUE;
                    last_winner_nxt = pick;
                    lat_id_nxt      = pick;
                    lat_we_nxt      = pick_we;
                    ram_addr_nxt    = pick_addr;
                    ram_wdata_nxt   = pick_wdata;
                    ram_wr_nxt      = pick_we;
                    ram_rd_nxt      = ~pick_we;
                    gnt_nxt         = id_onehot(pick);
                end else begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                cnt_nxt = 2'd0;
                if (lat_we) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RWAIT;
                end
            end
            RWAIT: begin
                if (cnt == LAT_LAST) begin
                    // ram_rdata is valid on this edge; the rvalid pulse
                    // lands in the following IDLE cycle.
                    state_nxt  = IDLE;
                    rdata_nxt  = ram_rdata;
                    rvalid_nxt = id_onehot(lat_id);
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset also drops any read in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_winner <= MASTER_STACK;
            lat_we      <= 1'b0;
            lat_id      <= MASTER_CPU;
            cnt         <= 2'd0;
            gnt         <= 2'b00;
            rvalid      <= 2'b00;
            ram_rd      <= 1'b0;
            ram_wr      <= 1'b0;
            ram_addr    <= {ADDR_W{1'b0}};
            ram_wdata   <= {DATA_W{1'b0}};
            rdata       <= {DATA_W{1'b0}};
        end else begin
            state       <= state_nxt;
            last_winner <= last_winner_nxt;
            lat_we      <= lat_we_nxt;
            lat_id      <= lat_id_nxt;
            cnt         <= cnt_nxt;
            gnt         <= gnt_nxt;
            rvalid      <= rvalid_nxt;
            ram_rd      <= ram_rd_nxt;
            ram_wr      <= ram_wr_nxt;
            ram_addr    <= ram_addr_nxt;
            ram_wdata   <= ram_wdata_nxt;
            rdata       <= rdata_nxt;
        end
    end

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = rvalid[0];
    assign m1_rvalid = rvalid[1];

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single-port data RAM (12-bit address, 14-bit data) between the CPU control unit's load/store path (master 0) and the stack unit's spill/fill path (master 1). It accepts one request at a time with round-robin fairness and drives the RAM strobes. For reads it waits the RAM's fixed read latency and returns the data to the winning master with a one-cycle valid pulse. It sits between `control`/`stack` and `ram` on the general data bus.

## Interface
- `DATA_W`, 14, data width
- `ADDR_W`, 12, address width
- `RD_LAT`, 1, RAM read latency in cycles; legal range 1..4
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low reset; 0 clears all state immediately
- `m0_req`, `m1_req`  in  1  access request; held high until that master's gnt is seen
- `m0_we`, `m1_we`  in  1  1 = write, 0 = read; stable while req high
- `m0_addr`, `m1_addr`  in  ADDR_W  access address; stable while req high
- `m0_wdata`, `m1_wdata`  in  DATA_W  write data; stable while req high
- `m0_gnt`, `m1_gnt`  out  1  one-cycle pulse: request accepted and issued to RAM
- `m0_rvalid`, `m1_rvalid`  out  1  one-cycle pulse: `rdata` holds this master's read result
- `rdata`  out  DATA_W  read data, shared by both masters; qualify with rvalid
- `ram_addr`  out  ADDR_W  RAM address
- `ram_wdata`  out  DATA_W  RAM write data
- `ram_rd`  out  1  RAM read strobe, one cycle
- `ram_wr`  out  1  RAM write strobe, one cycle
- `ram_rdata`  in  DATA_W  RAM read data; valid RD_LAT cycles after the cycle with `ram_rd`

## Operation
- FSM has three states:
  - IDLE: if any req is high, pick the winner, latch its we/addr/wdata and id, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: drive `ram_addr` and `ram_wdata` from the latched values, assert `ram_wr` (write) or `ram_rd` (read), and pulse the winner's gnt. A write returns to IDLE; a read goes to RWAIT.
  - RWAIT: a 2-bit counter runs for RD_LAT cycles. On the last RWAIT edge, capture `ram_rdata` into `rdata` and return to IDLE. The winner's rvalid is high during the first IDLE cycle that follows.
- Round-robin rule:
  - If only one master requests, that master wins.
  - If both request, the master that is not `last_winner` wins.
  - `last_winner` updates on every IDLE→ISSUE transition.
  - `last_winner` resets to 1, so master 0 wins the first tie.
- Requests are not sampled outside IDLE. A req that rises during ISSUE or RWAIT waits until the next IDLE.
- A master drops req in the cycle after its gnt. A req still high in IDLE after a gnt is treated as a new request.
- `rdata` holds its last captured value until the next read completes.
- All outputs are registered. No combinational path runs from any input to any output.
- Reset, including mid-transaction:
  - state = IDLE, `last_winner` = 1.
  - All gnt, rvalid, `ram_rd` and `ram_wr` = 0.
  - `ram_addr`, `ram_wdata` and `rdata` = 0.
  - An in-flight read is dropped and never produces an rvalid.

## Timing
- Cycle 0: req seen high at the closing edge. Cycle 1: ISSUE, with gnt and the RAM strobe high.
- Write:
  - Occupancy is 2 cycles.
  - A new arbitration is possible in cycle 2, with the next ISSUE in cycle 3.
- Read:
  - `ram_rd` is high in cycle 1.
  - RWAIT covers cycles 2..1+RD_LAT.
  - rvalid and `rdata` are valid in cycle 2+RD_LAT.
  - That IDLE cycle may arbitrate a new request in the same cycle.
- Back-to-back worst case: a 2-cycle gap between consecutive gnt pulses for writes, and RD_LAT+2 cycles for reads.
- gnt and rvalid are never high for both masters at once. `ram_rd` and `ram_wr` are never high together.

## Structure
- Shared package `cpu_pkg`:
  - DATA_W = 14 and ADDR_W = 12.
  - FSM state encodings: IDLE = 2'd0, ISSUE = 2'd1, RWAIT = 2'd2.
  - The MASTER_CPU = 0 and MASTER_STACK = 1 ids.
- One sub-module, `rr_pick2`: combinational round-robin picker. Inputs are the 2-bit req vector and `last_winner`; outputs are the winner id and an any-request flag. The FSM, latches and counter stay in `mem_arbiter`.

## Test plan
- Reset: drive `reset` low mid-simulation → all outputs 0 on the same cycle, asynchronously; after release, state is IDLE.
- m0 write of addr 0x123, data 0x2A5 → `m0_gnt` and `ram_wr` high in cycle 1 with `ram_addr` = 0x123 and `ram_wdata` = 0x2A5; no rvalid.
- m0 read of 0x123 with RD_LAT = 1 and RAM model returning 0x2A5 → `ram_rd` in cycle 1, `m0_rvalid` = 1 with `rdata` = 0x2A5 in cycle 3, `m1_rvalid` stays 0.
- Both masters hold write requests for 4 grants → gnt order m0, m1, m0, m1, with gnt pulses 2 cycles apart.
- m1 requests a read while m0's write is in ISSUE → m1 gets gnt at the next ISSUE; its rvalid arrives RD_LAT+1 cycles after its gnt.
- `reset` asserted during RWAIT of an m1 read → no `m1_rvalid` ever; after release, a new m0 request wins the first tie, confirming `last_winner` was reset.
